bf16_norm: RTL and testbench

BF16_NORM -- requirements
Module: bf16_norm

---
 rtl/bf16_norm.sv | 169 ++++++++++++++++
 tb/tb_bf16_norm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bf16_norm.sv
// ============================================================================
// Module   : bf16_norm
// Brief    : Two-stage normalizer, unnormalized magnitude + exponent -> BF16.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bf16_norm #(
    parameter int W  = 16,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         sign_i,
    input  logic [7:0]   exp_i,
    input  logic [W-1:0] mant_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [15:0]  data_o,
    output logic         zero_o,
    output logic         uf_o
);

    localparam int c_lvl = $clog2(W);
    localparam int c_ext = (CW > 9) ? CW : 9;

    logic           v1_q, v1_d;
    logic           sign1_q, sign1_d;
    logic [7:0]     exp1_q, exp1_d;
    logic [W-1:0]   mant1_q, mant1_d;
    logic [CW-1:0]  lz1_q, lz1_d;

    logic           v2_q, v2_d;
    logic [15:0]    data2_q, data2_d;
    logic           zero2_q, zero2_d;
    logic           uf2_q, uf2_d;

    logic           w_s2_load;
    logic           w_s1_load;

    assign w_s2_load = ~v2_q | ready_i;
    assign w_s1_load = ~v1_q | w_s2_load;
    assign ready_o   = w_s1_load;

    // Leading-zero count: each level tests the upper half of the remaining
    // window and shifts it out when zero, yielding one count bit per level.
    logic [W-1:0]     w_lz_x [c_lvl];
    logic [c_lvl-1:0] w_lz_bits;
    logic [CW-1:0]    w_lz;
    logic             w_mant_zero;

    assign w_lz_x[0] = mant_i;

    genvar k;
    generate
        for (k = 0; k < c_lvl; k++) begin : g_lz_lvl
            localparam int c_sh = 1 << (c_lvl - 1 - k);
            assign w_lz_bits[c_lvl-1-k] = ~|w_lz_x[k][W-1 -: c_sh];
            if (k < c_lvl - 1) begin : g_fwd
                assign w_lz_x[k+1] = w_lz_bits[c_lvl-1-k] ? (w_lz_x[k] << c_sh)
                                                          : w_lz_x[k];
            end
        end
    endgenerate

    assign w_mant_zero = ~|mant_i;
    assign w_lz        = w_mant_zero ? CW'(W) : CW'(w_lz_bits);

    always_comb begin
        v1_d    = v1_q;
        sign1_d = sign1_q;
        exp1_d  = exp1_q;
        mant1_d = mant1_q;
        lz1_d   = lz1_q;
        if (w_s1_load) begin
            v1_d = valid_i;
            if (valid_i) begin
                sign1_d = sign_i;
                exp1_d  = exp_i;
                mant1_d = mant_i;
                lz1_d   = w_lz;
            end
        end
    end

    logic [W-1:0]     w_shifted;
    logic [c_ext-1:0] w_exp_ext;
    logic [c_ext-1:0] w_lz_ext;
    logic [7:0]       w_exp_out;
    logic [15:0]      w_res;
    logic             w_res_zero;
    logic             w_res_uf;

    assign w_shifted = mant1_q << lz1_q;
    assign w_exp_ext = c_ext'(exp1_q);
    assign w_lz_ext  = c_ext'(lz1_q);
    // Only reached when lz < exp <= 254, so the low byte of lz is exact.
    assign w_exp_out = exp1_q - w_lz_ext[7:0];

    always_comb begin
        w_res      = {sign1_q, exp1_q, mant1_q[W-2 -: 7]};
        w_res_zero = 1'b0;
        w_res_uf   = 1'b0;
        if (exp1_q == 8'hFF) begin
            w_res = {sign1_q, 8'hFF, mant1_q[W-2 -: 7]};
        end else if (lz1_q == CW'(W)) begin
            w_res      = {sign1_q, 15'b0};
            w_res_zero = 1'b1;
        end else if (w_exp_ext <= w_lz_ext) begin
            w_res    = {sign1_q, 15'b0};
            w_res_uf = 1'b1;
        end else begin
            w_res = {sign1_q, w_exp_out, w_shifted[W-2 -: 7]};
        end
    end

    logic w_unused_bits;
    assign w_unused_bits = ^{w_shifted[W-1], w_shifted[W-9:0],
                             w_lz_x[c_lvl-1][W-2:0]};

    always_comb begin
        v2_d    = v2_q;
        data2_d = data2_q;
        zero2_d = zero2_q;
        uf2_d   = uf2_q;
        if (w_s2_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                data2_d = w_res;
                zero2_d = w_res_zero;
                uf2_d   = w_res_uf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            sign1_q <= 1'b0;
            exp1_q  <= 8'h00;
            mant1_q <= '0;
            lz1_q   <= '0;
            v2_q    <= 1'b0;
            data2_q <= 16'h0000;
            zero2_q <= 1'b0;
            uf2_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            sign1_q <= sign1_d;
            exp1_q  <= exp1_d;
            mant1_q <= mant1_d;
            lz1_q   <= lz1_d;
            v2_q    <= v2_d;
            data2_q <= data2_d;
            zero2_q <= zero2_d;
            uf2_q   <= uf2_d;
        end
    end

    assign valid_o = v2_q;
    assign data_o  = data2_q;
    assign zero_o  = zero2_q;
    assign uf_o    = uf2_q;

endmodule

`default_nettype wire

// File: tb/tb_bf16_norm.sv
// ============================================================================
// Module   : tb_bf16_norm
// Brief    : Directed vector table plus backpressure and reset sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bf16_norm;

    localparam int NV = 13;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = 8'h00;
    logic [15:0] mant_i = 16'h0000;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [15:0] data_o;
    logic        zero_o;
    logic        uf_o;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        sign;
        logic [7:0]  exp;
        logic [15:0] mant;
        logic [15:0] data;
        logic        zero;
        logic        uf;
    } vec_t;

    vec_t vecs [NV];

    bf16_norm #(.W(16)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sign_i  (sign_i),
        .exp_i   (exp_i),
        .mant_i  (mant_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .zero_o  (zero_o),
        .uf_o    (uf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic drive(input int i);
        valid_i = 1'b1;
        sign_i  = vecs[i].sign;
        exp_i   = vecs[i].exp;
        mant_i  = vecs[i].mant;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'd127, 16'h8000, 16'h3F80, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd130, 16'h00C0, 16'h3D40, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'd50,  16'h0000, 16'h8000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'd10,  16'h0001, 16'h0000, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hFF,  16'h0123, 16'hFF81, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'hFF,  16'h0000, 16'h7F80, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd8,   16'h00C0, 16'h0000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'd9,   16'h00C0, 16'h80C0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'd200, 16'hFFFF, 16'h647F, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 8'hFE,  16'h8000, 16'h7F00, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'd3,   16'h7FFF, 16'h817F, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 8'd100, 16'h0001, 16'h2A80, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 8'd0,   16'h0000, 16'h0000, 1'b1, 1'b0};

        // Reset state
        step();
        chk("rst_valid", 16'(valid_o), 16'd0);
        chk("rst_data",  data_o,       16'h0000);
        chk("rst_zero",  16'(zero_o),  16'd0);
        chk("rst_uf",    16'(uf_o),    16'd0);
        chk("rst_ready", 16'(ready_o), 16'd1);
        rst = 1'b0;

        // Streaming table, one operand per cycle, result two cycles later
        ready_i = 1'b1;
        for (int c = 0; c < NV + 2; c++) begin
            if (c < NV) drive(c);
            else valid_i = 1'b0;
            #1;
            chk($sformatf("tput_ready_%0d", c), 16'(ready_o), 16'd1);
            step();
            if (c == 0) begin
                chk("lat_valid_early", 16'(valid_o), 16'd0);
            end else if (c <= NV) begin
                chk($sformatf("v%0d_valid", c - 1), 16'(valid_o), 16'd1);
                chk($sformatf("v%0d_data",  c - 1), data_o, vecs[c-1].data);
                chk($sformatf("v%0d_zero",  c - 1), 16'(zero_o), 16'(vecs[c-1].zero));
                chk($sformatf("v%0d_uf",    c - 1), 16'(uf_o),   16'(vecs[c-1].uf));
            end else begin
                chk("stream_drain_valid", 16'(valid_o), 16'd0);
            end
        end

        // Backpressure: three back-to-back operands, ready_i low for 4 cycles
        ready_i = 1'b0;
        drive(8);
        #1;
        chk("bp_ready_t0", 16'(ready_o), 16'd1);
        step();
        drive(9);
        #1;
        chk("bp_ready_t1", 16'(ready_o), 16'd1);
        step();
        chk("bp_valid_t2", 16'(valid_o), 16'd1);
        chk("bp_data_t2", data_o, vecs[8].data);
        drive(10);
        #1;
        chk("bp_full_t2", 16'(ready_o), 16'd0);
        step();
        chk("bp_frozen_t3", data_o, vecs[8].data);
        chk("bp_full_t3", 16'(ready_o), 16'd0);
        step();
        chk("bp_frozen_t4", data_o, vecs[8].data);
        chk("bp_valid_t4", 16'(valid_o), 16'd1);
        ready_i = 1'b1;
        #1;
        chk("bp_ready_release", 16'(ready_o), 16'd1);
        step();
        chk("bp_second", data_o, vecs[9].data);
        chk("bp_second_valid", 16'(valid_o), 16'd1);
        valid_i = 1'b0;
        step();
        chk("bp_third", data_o, vecs[10].data);
        chk("bp_third_valid", 16'(valid_o), 16'd1);
        step();
        chk("bp_drain_valid", 16'(valid_o), 16'd0);

        // Reset pulse with two operands in flight
        drive(1);
        step();
        drive(2);
        step();
        chk("rp_pre_valid", 16'(valid_o), 16'd1);
        valid_i = 1'b0;
        rst = 1'b1;
        #1;
        chk("rp_async_valid", 16'(valid_o), 16'd0);
        chk("rp_async_data", data_o, 16'h0000);
        chk("rp_async_ready", 16'(ready_o), 16'd1);
        step();
        rst = 1'b0;
        drive(7);
        #1;
        chk("rp_post_ready", 16'(ready_o), 16'd1);
        step();
        chk("rp_nostale", 16'(valid_o), 16'd0);
        valid_i = 1'b0;
        step();
        chk("rp_new_valid", 16'(valid_o), 16'd1);
        chk("rp_new_data", data_o, vecs[7].data);
        step();
        chk("rp_drain_valid", 16'(valid_o), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
